// File: rtl/contador_mod_bcd.sv
// Modulo up/down counter with BCD output, button auto-repeat, load strobe and cascade tick.
// Count is binary internally; datos_BCD is decoded combinationally from the count register.
module contador_mod_bcd #(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 23,
  parameter int SEL_W   = 4,
  parameter int SEL_ID  = 10,
  parameter int DLY_CYC = 50_000_000,
  parameter int RPT_CYC = 12_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] contadores,
  input  logic             Arriba,
  input  logic             Abajo,
  input  logic             inc_tick,
  input  logic             cargar,
  input  logic [7:0]       dato_carga,
  output logic [7:0]       datos_BCD,
  output logic             acarreo,
  output logic             prestamo,
  output logic             editando
);

  localparam int TMR_MAX = (DLY_CYC > RPT_CYC) ? DLY_CYC : RPT_CYC;
  localparam int TW      = $clog2(TMR_MAX + 1);

  localparam logic [6:0]       MIN_C = 7'(MIN_VAL);
  localparam logic [6:0]       MAX_C = 7'(MAX_VAL);
  localparam logic [SEL_W-1:0] SEL_C = SEL_W'(SEL_ID);
  localparam logic [TW-1:0]    DLY_C = TW'(DLY_CYC);
  localparam logic [TW-1:0]    RPT_C = TW'(RPT_CYC);
  localparam logic [TW-1:0]    ONE_C = TW'(1);
  localparam logic [TW-1:0]    ZERO_C = '0;

  logic [6:0]    count;
  logic [1:0]    btn_prev;   // {Arriba, Abajo} as sampled on the previous edge
  logic [TW-1:0] hold_tmr;

  logic sel, both;
  logic press_up, press_dn, held, rpt;
  logic step_up, step_dn, tick_up;
  logic ld_ok;
  int   ld_int;

  always_comb begin
    sel      = (contadores == SEL_C);
    both     = Arriba & Abajo;
    press_up = sel & ~both & Arriba & ~btn_prev[1];
    press_dn = sel & ~both & Abajo  & ~btn_prev[0];
    held     = sel & ~both & ((Arriba & btn_prev[1]) | (Abajo & btn_prev[0]));
    // Timer holds the number of edges left until the next repeat step
    rpt      = held & (hold_tmr == ONE_C);
    step_up  = press_up | (rpt & Arriba);
    step_dn  = press_dn | (rpt & Abajo);
    tick_up  = ~sel & inc_tick;

    ld_int = int'(dato_carga[7:4]) * 10 + int'(dato_carga[3:0]);
    ld_ok  = cargar && (dato_carga[7:4] <= 4'd9) && (dato_carga[3:0] <= 4'd9) &&
             (ld_int >= MIN_VAL) && (ld_int <= MAX_VAL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= MIN_C;
      acarreo  <= 1'b0;
      prestamo <= 1'b0;
      editando <= 1'b0;
    end else begin
      editando <= sel;
      acarreo  <= 1'b0;
      prestamo <= 1'b0;
      if (ld_ok) begin
        count <= 7'(ld_int);
      end else if (step_up || tick_up) begin
        if (count == MAX_C) begin
          count   <= MIN_C;
          acarreo <= 1'b1;
        end else begin
          count <= count + 7'd1;
        end
      end else if (step_dn) begin
        if (count == MIN_C) begin
          count    <= MAX_C;
          prestamo <= 1'b1;
        end else begin
          count <= count - 7'd1;
        end
      end
    end
  end

  // Button history and hold timer run independently of whether a load wins the edge
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev <= 2'b00;
      hold_tmr <= ZERO_C;
    end else if (!sel || both) begin
      btn_prev <= 2'b00;
      hold_tmr <= ZERO_C;
    end else begin
      btn_prev <= {Arriba, Abajo};
      if (press_up || press_dn)
        hold_tmr <= DLY_C;
      else if (rpt)
        hold_tmr <= RPT_C;
      else if (held && hold_tmr != ZERO_C)
        hold_tmr <= hold_tmr - ONE_C;
      else if (!held)
        hold_tmr <= ZERO_C;
    end
  end

  always_comb begin
    datos_BCD[7:4] = 4'(count / 7'd10);
    datos_BCD[3:0] = 4'(count % 7'd10);
  end

endmodule
